// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM state encoding, default limits
// and the checksum accumulate helper.
package boot_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HEADER = 3'd1,
      ST_LOAD   = 3'd2,
      ST_CHECK  = 3'd3,
      ST_DONE   = 3'd4,
      ST_ERROR  = 3'd5
   } boot_state_e;

   localparam logic [31:0] DEF_ADDR_BASE = 32'h0000_0000;
   localparam int unsigned DEF_MAX_WORDS = 32'd256;
   localparam int unsigned DEF_TIMEOUT   = 32'd1023;

   // Checksum is a plain 32-bit sum that wraps modulo 2^32.
   function automatic logic [31:0] csum_add(input logic [31:0] acc, input logic [31:0] word);
      return acc + word;
   endfunction

   function automatic logic is_active(input boot_state_e s);
      return (s == ST_HEADER) || (s == ST_LOAD) || (s == ST_CHECK);
   endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Stream input handshake plus instruction-memory write bus of the boot loader.
interface boot_loader_if;

   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic [31:0] mem_address;
   logic [31:0] mem_data;
   logic        mem_we;

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output mem_address,
      output mem_data,
      output mem_we
   );

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  mem_address,
      input  mem_data,
      input  mem_we
   );

endinterface

// File: rtl/boot_timeout.sv
// Inter-word idle counter: cleared on a transfer, counts idle cycles while a
// load is active, and flags expiry on the TIMEOUT-th consecutive idle cycle.
module boot_timeout
   import boot_loader_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic count,
   output logic expired
);

   localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

   logic [31:0] count_q;
   logic [31:0] count_d;

   // Next count and expiry decode; clear has priority over counting.
   always_comb begin
      count_d = count_q;
      expired = 1'b0;
      if (clear) begin
         count_d = 32'd0;
      end else if (count) begin
         if ((count_q + 32'd1) >= TIMEOUT_W) begin
            expired = 1'b1;
            count_d = count_q;
         end else begin
            count_d = count_q + 32'd1;
         end
      end else begin
         count_d = count_q;
      end
   end

   // Idle-cycle counter register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         count_q <= 32'd0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/boot_loader.sv
// Streams a length-prefixed, checksummed program into instruction memory and
// holds the core off until the image has been loaded and verified.
module boot_loader
   import boot_loader_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE = DEF_ADDR_BASE,
   parameter int unsigned MAX_WORDS = DEF_MAX_WORDS,
   parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   boot_loader_if.slave  bus,
   output logic          on_bios,
   output logic          enable_core,
   output logic          error,
   output logic [31:0]   word_count
);

   localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

   boot_state_e state_q, state_d;
   logic [31:0] len_q, len_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] word_count_q, word_count_d;
   logic [31:0] mem_address_q, mem_address_d;
   logic [31:0] mem_data_q, mem_data_d;
   logic        mem_we_q, mem_we_d;
   logic        in_ready_q, in_ready_d;
   logic        on_bios_q, on_bios_d;
   logic        enable_core_q, enable_core_d;
   logic        error_q, error_d;

   logic        xfer_s;
   logic        tmo_clear_s;
   logic        tmo_count_s;
   logic        tmo_expired_s;

   assign xfer_s = bus.in_valid && in_ready_q;

   boot_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clock   (clock),
      .reset   (reset),
      .clear   (tmo_clear_s),
      .count   (tmo_count_s),
      .expired (tmo_expired_s)
   );

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      acc_d         = acc_q;
      word_count_d  = word_count_q;
      mem_address_d = mem_address_q;
      mem_data_d    = mem_data_q;
      mem_we_d      = 1'b0;
      tmo_clear_s   = 1'b0;
      tmo_count_s   = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            // in_ready is low here, so a start never races a consumed word.
            tmo_clear_s = 1'b1;
            if (start) begin
               state_d      = ST_HEADER;
               word_count_d = 32'd0;
               acc_d        = 32'd0;
            end else begin
               state_d = state_q;
            end
         end
         ST_HEADER: begin
            tmo_clear_s = xfer_s;
            tmo_count_s = !xfer_s;
            if (xfer_s) begin
               len_d = bus.in_data;
               if (bus.in_data > MAX_WORDS_W) begin
                  state_d = ST_ERROR;
               end else if (bus.in_data == 32'd0) begin
                  state_d = ST_CHECK;
               end else begin
                  state_d = ST_LOAD;
               end
            end else if (tmo_expired_s) begin
               state_d = ST_ERROR;
            end else begin
               state_d = ST_HEADER;
            end
         end
         ST_LOAD: begin
            tmo_clear_s = xfer_s;
            tmo_count_s = !xfer_s;
            if (xfer_s) begin
               mem_we_d      = 1'b1;
               mem_address_d = ADDR_BASE + word_count_q;
               mem_data_d    = bus.in_data;
               acc_d         = csum_add(acc_q, bus.in_data);
               word_count_d  = word_count_q + 32'd1;
               if (word_count_q == (len_q - 32'd1)) begin
                  state_d = ST_CHECK;
               end else begin
                  state_d = ST_LOAD;
               end
            end else if (tmo_expired_s) begin
               state_d = ST_ERROR;
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_CHECK: begin
            tmo_clear_s = xfer_s;
            tmo_count_s = !xfer_s;
            if (xfer_s) begin
               if (bus.in_data == acc_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ERROR;
               end
            end else if (tmo_expired_s) begin
               state_d = ST_ERROR;
            end else begin
               state_d = ST_CHECK;
            end
         end
         default: begin
            state_d = ST_ERROR;
         end
      endcase

      in_ready_d    = is_active(state_d);
      on_bios_d     = is_active(state_d);
      enable_core_d = (state_d == ST_DONE);
      error_d       = (state_d == ST_ERROR);
   end

   // State, datapath and output registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         len_q         <= 32'd0;
         acc_q         <= 32'd0;
         word_count_q  <= 32'd0;
         mem_address_q <= 32'd0;
         mem_data_q    <= 32'd0;
         mem_we_q      <= 1'b0;
         in_ready_q    <= 1'b0;
         on_bios_q     <= 1'b0;
         enable_core_q <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         acc_q         <= acc_d;
         word_count_q  <= word_count_d;
         mem_address_q <= mem_address_d;
         mem_data_q    <= mem_data_d;
         mem_we_q      <= mem_we_d;
         in_ready_q    <= in_ready_d;
         on_bios_q     <= on_bios_d;
         enable_core_q <= enable_core_d;
         error_q       <= error_d;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.mem_address = mem_address_q;
   assign bus.mem_data    = mem_data_q;
   assign bus.mem_we      = mem_we_q;
   assign on_bios         = on_bios_q;
   assign enable_core     = enable_core_q;
   assign error           = error_q;
   assign word_count      = word_count_q;

endmodule
